// File: rtl/clyde_tk_w_sched.sv
// clyde_tk_w_sched -- tweak/round-constant sequencer for the masked TK/W adder.
//
// Holds the public tweak and steps it through the period-3 Clyde tweak
// schedule. Runs the 4-bit round-constant LFSR and issues the per-phase TK/W
// enables. Each phase is held until the datapath strobes adv.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, tweak      begin a schedule and capture {t0,t1}; only seen in IDLE
//   adv               datapath consumed the current phase
//   delta             current tweak word {a,b}
//   W                 current round constant (0 outside ROUND)
//   ctrl_TK_addition  add tweakey this phase
//   ctrl_W_addition   add round constant this phase
//   round             current round index
//   busy              schedule in progress (INIT or ROUND)
//   done              one-cycle pulse after the last round is consumed
//
// state | meaning
// IDLE  | waiting for start; delta keeps the last tweak word
// INIT  | initial whitening: TK only, round 0
// ROUND | round r: W = lfsr, TK on odd r
// DONE  | single-cycle done pulse, then back to IDLE
module clyde_tk_w_sched #(
  parameter int Nbits  = 128,
  parameter int ROUNDS = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [Nbits-1:0]          tweak,
  input  logic                      adv,
  output logic [Nbits-1:0]          delta,
  output logic [3:0]                W,
  output logic                      ctrl_TK_addition,
  output logic                      ctrl_W_addition,
  output logic [$clog2(ROUNDS)-1:0] round,
  output logic                      busy,
  output logic                      done
);

  localparam int H  = Nbits / 2;
  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [H-1:0]  a_q, a_d;
  logic [H-1:0]  b_q, b_d;
  logic [3:0]    lfsr_q, lfsr_d;
  logic [RW-1:0] r_q, r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      lfsr_q  <= 4'b0001;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lfsr_q  <= lfsr_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    lfsr_d  = lfsr_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = tweak[Nbits-1:H];
          b_d     = tweak[H-1:0];
          lfsr_d  = 4'b0001;
          r_d     = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (adv) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (adv) begin
          if (r_q == LAST_R) begin
            state_d = S_DONE;
          end else begin
            r_d    = r_q + 1'b1;
            lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
            // Tweak steps on entry to each odd round, i.e. once per 2-round
            // step, so the TK addition after step s sees tweak s (mod 3).
            if (!r_q[0]) begin
              a_d = a_q ^ b_q;
              b_d = a_q;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    delta            = {a_q, b_q};
    W                = 4'd0;
    ctrl_TK_addition = 1'b0;
    ctrl_W_addition  = 1'b0;
    round            = r_q;
    busy             = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      S_INIT: begin
        busy             = 1'b1;
        ctrl_TK_addition = 1'b1;
      end
      S_ROUND: begin
        busy             = 1'b1;
        ctrl_W_addition  = 1'b1;
        ctrl_TK_addition = r_q[0];
        W                = lfsr_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_clyde_tk_w_sched.sv
module tb_clyde_tk_w_sched;

  localparam int N = 128;
  localparam int H = 64;
  localparam int R = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  tweak;
  logic          adv;
  logic [N-1:0]  delta;
  logic [3:0]    W;
  logic          ctrl_TK_addition;
  logic          ctrl_W_addition;
  logic [3:0]    round;
  logic          busy;
  logic          done;

  clyde_tk_w_sched #(.Nbits(N), .ROUNDS(R)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .tweak            (tweak),
    .adv              (adv),
    .delta            (delta),
    .W                (W),
    .ctrl_TK_addition (ctrl_TK_addition),
    .ctrl_W_addition  (ctrl_W_addition),
    .round            (round),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit           is_done;
    logic [N-1:0] delta;
    logic [3:0]   w;
    bit           tk;
    bit           wen;
    int           rnd;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  bit   cur_valid = 1'b0;

  logic [3:0] wtab [R] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6,
                           4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected required=none (t=%0t)", name, $time);
  endtask

  // Reference: INIT, then R rounds, then a done pulse. Tweak for round r is
  // element ((r+1)/2) mod 3 of the period-3 tweak sequence.
  task automatic push_run(input logic [N-1:0] tw);
    logic [H-1:0] t0, t1;
    logic [N-1:0] tws [3];
    exp_t e;
    t0 = tw[N-1:H];
    t1 = tw[H-1:0];
    tws[0] = {t0, t1};
    tws[1] = {t0 ^ t1, t0};
    tws[2] = {t1, t0 ^ t1};
    e = '{is_done: 1'b0, delta: tws[0], w: 4'h0, tk: 1'b1, wen: 1'b0, rnd: 0};
    sbq.push_back(e);
    for (int r = 0; r < R; r++) begin
      e = '{is_done: 1'b0, delta: tws[((r + 1) / 2) % 3], w: wtab[r],
            tk: bit'(r % 2), wen: 1'b1, rnd: r};
      sbq.push_back(e);
    end
    e = '{is_done: 1'b1, delta: '0, w: 4'h0, tk: 1'b0, wen: 1'b0, rnd: 0};
    sbq.push_back(e);
  endtask

  // Monitor: samples adv as the DUT sees it, compares at the falling edge.
  logic adv_s = 1'b0;
  bit   busy_p = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  always @(posedge clk) adv_s = adv;

  always @(negedge clk) begin
    if (rst) begin
      busy_p    = 1'b0;
      cur_valid = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sbq.size() == 0 || !sbq[0].is_done) flag("unexpected_done");
        else void'(sbq.pop_front());
        chk("done_busy", N'(busy), '0);
        chk("done_ctrl", N'({ctrl_TK_addition, ctrl_W_addition}), '0);
        chk("done_W", N'(W), '0);
      end
      if (busy) begin
        if (!busy_p || adv_s) begin
          if (sbq.size() == 0 || sbq[0].is_done) begin
            flag("unexpected_phase");
            cur_valid = 1'b0;
          end else begin
            cur = sbq.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (cur_valid) begin
          chk("delta", delta, cur.delta);
          chk("W", N'(W), N'(cur.w));
          chk("ctrl_TK", N'(ctrl_TK_addition), N'(cur.tk));
          chk("ctrl_W", N'(ctrl_W_addition), N'(cur.wen));
          chk("round", N'(round), N'(cur.rnd));
          chk("done_while_busy", N'(done), '0);
        end
      end else if (!done) begin
        chk("idle_ctrl", N'({ctrl_TK_addition, ctrl_W_addition}), '0);
        chk("idle_W", N'(W), '0);
      end
      busy_p = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_tw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_delta"}, delta, '0);
    chk({tag, "_W"}, N'(W), '0);
    chk({tag, "_ctrl"}, N'({ctrl_TK_addition, ctrl_W_addition}), '0);
    chk({tag, "_round"}, N'(round), '0);
    chk({tag, "_busy_done"}, N'({busy, done}), '0);
  endtask

  // mode: 0 adv every 3 cycles, 1 adv held high, 2 random gaps,
  // 3 50-cycle stall while round 2 is presented. rst_phase >= 0 asserts
  // reset while waiting on that phase (phase 0 = INIT, phase p = round p-1).
  task automatic run(input logic [N-1:0] tw, input int mode, input bit adv_with_start,
                     input int rst_phase);
    int d0, init_cyc, gap;
    start = 1'b1;
    tweak = tw;
    adv   = adv_with_start;
    push_run(tw);
    d0 = done_cnt;
    tick();
    init_cyc = cyc;
    start = 1'b0;
    for (int p = 0; p <= R; p++) begin
      case (mode)
        0:       gap = 2;
        1:       gap = 0;
        3:       gap = (p == 3) ? 50 : int'($urandom_range(0, 2));
        default: gap = int'($urandom_range(0, 4));
      endcase
      if (p == rst_phase) begin
        adv = 1'b0;
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1 reset_checks("midrun_reset");
        sbq.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_busy", N'(busy), '0);
        chk("post_reset_round", N'(round), '0);
        return;
      end
      for (int g = 0; g < gap; g++) begin
        adv   = 1'b0;
        start = (p == 5) ? 1'b1 : ($urandom_range(0, 2) == 0);
        tweak = rand_tw();
        tick();
      end
      adv   = 1'b1;
      start = (p == 5) ? 1'b1 : ($urandom_range(0, 2) == 0);
      tweak = rand_tw();
      tick();
    end
    // DUT now in DONE: start and adv here must be ignored.
    start = 1'b1;
    tweak = rand_tw();
    adv   = 1'b1;
    tick();
    start = 1'b0;
    adv   = 1'($urandom_range(0, 1));
    tick();
    tick();
    adv = 1'b0;
    tick();
    chk("done_count", N'(done_cnt - d0), N'(1));
    if (mode == 1) chk("b2b_latency", N'(done_cyc - init_cyc), N'(13));
    chk("scoreboard_drained", N'(sbq.size()), '0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    adv   = 1'b0;
    tweak = '0;
    #2 rst = 1'b1;
    #1 reset_checks("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", N'(busy), '0);

    run({64'h1, 64'h2}, 0, 1'b0, -1);
    run({64'h1, 64'h2}, 1, 1'b0, -1);
    run(rand_tw(), 2, 1'b1, -1);
    run(rand_tw(), 3, 1'b0, -1);
    run(rand_tw(), 2, 1'b0, 7);
    run(rand_tw(), 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      run(rand_tw(), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
